registered_adder: RTL and testbench

- Parameterised registered ripple-carry adder: computes s = a + b + cin, with carry-out cout.
- Inputs and outputs both pass through register stages, so every path is register-to-register. This makes the block a timing benchmark for the configurable fabric's maximum-clock search.
- It is the user design mapped into the fabric, and it also serves as the golden reference model during fabric verification.

---
 rtl/adder_pkg.sv | 17 +
 rtl/full_adder_cell.sv | 13 +
 rtl/registered_adder.sv | 60 ++++++
 tb/tb_registered_adder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared width default and the reference sum used to check the registered adder.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 5;

  // Returns {carry, sum} of a + b + cin at the default width.
  function automatic logic [ADDER_WIDTH_DEFAULT:0] ref_add(
    input logic [ADDER_WIDTH_DEFAULT-1:0] a,
    input logic [ADDER_WIDTH_DEFAULT-1:0] b,
    input logic                           cin
  );
    logic [ADDER_WIDTH_DEFAULT:0] r;
    r = {1'b0, a} + {1'b0, b} + {{ADDER_WIDTH_DEFAULT{1'b0}}, cin};
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One bit of the ripple chain: sum is the 3-input parity, carry is the majority.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/registered_adder.sv
// Ripple-carry adder with registered inputs and outputs, so every path is
// register-to-register; outputs follow captured inputs by two edges.
module registered_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             sys_reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  // Stage 1: input capture
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end

  // Combinational carry chain between the two register stages
  assign c[0] = cin_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Stage 2: result capture
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_registered_adder.sv
// Scoreboard bench: stimulus queues expected {cout,s}; a monitor pops two edges later.
module tb_registered_adder;
  import adder_pkg::*;

  localparam int W = ADDER_WIDTH_DEFAULT;

  typedef struct {
    logic [W:0] val;
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         sys_reset_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] s;
  logic         cout;

  exp_t q[$];
  logic track = 1'b0;
  logic vld_p0, vld_p1;
  int   total = 0;
  int   bad = 0;

  registered_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .s           (s),
    .cout        (cout)
  );

  always #5 clk = ~clk;

  // Marks which edges captured a vector that has a scoreboard entry
  always @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= track;
      vld_p1 <= vld_p0;
    end
  end

  always @(negedge clk) begin
    if (vld_p1) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow got {cout,s}=%0d with nothing expected", {cout, s});
      end else begin
        e = q.pop_front();
        if ({cout, s} !== e.val) begin
          bad++;
          $display("FAIL %s got cout=%0d s=%0d required cout=%0d s=%0d",
                   e.name, cout, s, e.val[W], e.val[W-1:0]);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    total++;
    if (s !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL %s got cout=%0d s=%0d required cout=0 s=0", name, cout, s);
    end
  endtask

  // Called at a falling edge: drives one vector for the next rising edge.
  task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W:0] expv, input string name);
    exp_t e;
    a = av;
    b = bv;
    cin = cv;
    e.val = expv;
    e.name = name;
    q.push_back(e);
    track = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    a = 5'h1F;
    b = 5'h1F;
    cin = 1'b1;
    #1 check_zero("reset_immediate");
    repeat (2) @(negedge clk);
    check_zero("reset_held");

    sys_reset_n = 1'b1;
    apply(5'h1F, 5'h1F, 1'b1, 6'h3F, "reset_release_first");
    apply(5'd3, 5'd4, 1'b0, 6'd7, "add_3_4");
    apply(5'd10, 5'd5, 1'b1, 6'd16, "add_10_5_c");
    apply(5'd16, 5'd16, 1'b0, 6'h20, "wrap_16_16");
    apply(5'd31, 5'd0, 1'b1, 6'h20, "full_ripple");
    apply(5'd1, 5'd1, 1'b0, 6'd2, "pipe_1");
    apply(5'd2, 5'd2, 1'b0, 6'd4, "pipe_2");
    apply(5'd3, 5'd3, 1'b0, 6'd6, "pipe_3");
    apply(5'd9, 5'd9, 1'b0, 6'd18, "pre_reset");
    apply(5'd7, 5'd7, 1'b0, 6'd14, "in_flight");

    // 7+7 now sits in the input registers; kill it before it reaches s
    track = 1'b0;
    a = '0;
    b = '0;
    #2 sys_reset_n = 1'b0;
    q.delete();
    #1 check_zero("midreset_async");
    @(negedge clk);
    check_zero("midreset_held");
    @(negedge clk);
    check_zero("midreset_held2");
    sys_reset_n = 1'b1;
    apply(5'd5, 5'd6, 1'b1, 6'd12, "after_reset");
    apply(5'd31, 5'd31, 1'b1, 6'h3F, "max_sum");
    apply(5'd0, 5'd0, 1'b0, 6'd0, "zero_sum");

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom_range(0, 31));
      rb = W'($urandom_range(0, 31));
      rc = 1'($urandom_range(0, 1));
      apply(ra, rb, rc, ref_add(ra, rb, rc), "random");
    end

    track = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
